core_sequencer: RTL

Parametrised multi-cycle successor to the single-cycle core's sequencing and special-register logic. Owns the PC, the start/done handshake, the IM register, latched compare flags and SET_REG bank-extension bits, and adds a memory request/acknowledge stall so data memory may take any number of cycles. It sits between the instruction decoder and the datapath and issues a `commit` strobe that gates every architectural write.

---
 rtl/core_sequencer_pkg.sv | 18 +
 rtl/core_sequencer_pc_next.sv | 53 +++++
 rtl/core_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: FSM state encoding and branch condition codes.
// Pure definitions, no logic and no latency.
// No flow control lives here.
package core_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } seq_state_t;

  localparam logic [1:0] kCOND_ALWAYS = 2'b00;
  localparam logic [1:0] kCOND_EQ     = 2'b01;
  localparam logic [1:0] kCOND_LT     = 2'b10;
  localparam logic [1:0] kCOND_GT     = 2'b11;

endpackage

// File: rtl/core_sequencer_pc_next.sv
// Next-PC selection: evaluates the branch condition against latched flags and picks the successor PC.
// Purely combinational, zero cycles.
// No backpressure; the caller decides when the result is taken.
module pc_next_calc
  import core_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                halt_en,
  input  logic                abs_branch_en,
  input  logic                rel_branch_en,
  input  logic [1:0]          cond_sel,
  input  logic [3:0]          rel_offset,
  input  logic [PC_WIDTH-1:0] abs_target,
  input  logic                flag_lt,
  input  logic                flag_eq,
  input  logic                flag_gt,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic                cond_true;
  logic [PC_WIDTH-1:0] rel_ext;
  logic [PC_WIDTH-1:0] pc_one;

  assign rel_ext = {{(PC_WIDTH-4){rel_offset[3]}}, rel_offset};
  assign pc_one  = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Condition check uses only latched flags, so a CMP must retire before the branch that tests it.
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      kCOND_ALWAYS: cond_true = 1'b1;
      kCOND_EQ:     cond_true = flag_eq;
      kCOND_LT:     cond_true = flag_lt;
      kCOND_GT:     cond_true = flag_gt;
      default:      cond_true = 1'b0;
    endcase
  end

  // Priority: halt holds, then absolute branch, then relative branch, then sequential (wraps naturally).
  always_comb begin
    pc_next = pc + pc_one;
    if (halt_en) begin
      pc_next = pc;
    end else if (abs_branch_en && cond_true) begin
      pc_next = abs_target;
    end else if (rel_branch_en && cond_true) begin
      pc_next = pc + rel_ext;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: PC, start/done, IM, one-instruction flags and bank bits, memory stall; optional PERF_COUNTER_EN retired counter.
// commit is combinational in the retire cycle; 1 instr/cycle without memory, 1 + ack-wait cycles with memory.
// mem_req is held until mem_ack; all architectural state freezes while waiting.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int PC_WIDTH   = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_en,
  input  logic                  abs_branch_en,
  input  logic                  rel_branch_en,
  input  logic [1:0]            cond_sel,
  input  logic [3:0]            rel_offset,
  input  logic [PC_WIDTH-1:0]   abs_target,
  input  logic                  is_cmp,
  input  logic                  cmp_lt,
  input  logic                  cmp_eq,
  input  logic                  cmp_gt,
  input  logic                  load_imm_en,
  input  logic [DATA_WIDTH-1:0] imm_value,
  input  logic                  set_reg_en,
  input  logic [BANK_BITS-1:0]  dest_bank_in,
  input  logic [BANK_BITS-1:0]  src_bank_in,
  input  logic                  mem_access,
  input  logic                  mem_ack,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] im,
  output logic [BANK_BITS-1:0]  dest_bank,
  output logic [BANK_BITS-1:0]  src_bank,
  output logic                  flag_lt,
  output logic                  flag_eq,
  output logic                  flag_gt,
  output logic                  mem_req,
  output logic                  commit,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  seq_state_t          state;
  seq_state_t          state_next;
  logic                start_go;
  logic [PC_WIDTH-1:0] pc_next;

  pc_next_calc #(.PC_WIDTH(PC_WIDTH)) u_pc_next (
    .pc            (pc),
    .halt_en       (halt_en),
    .abs_branch_en (abs_branch_en),
    .rel_branch_en (rel_branch_en),
    .cond_sel      (cond_sel),
    .rel_offset    (rel_offset),
    .abs_target    (abs_target),
    .flag_lt       (flag_lt),
    .flag_eq       (flag_eq),
    .flag_gt       (flag_gt),
    .pc_next       (pc_next)
  );

  // State register; reset drops to IDLE at once so mem_req falls without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs; a memory instruction retires in the cycle its ack arrives.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    commit     = 1'b0;
    mem_req    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          start_go   = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        mem_req = mem_access;
        commit  = !mem_access || mem_ack;
        if (commit)          state_next = halt_en ? HALTED : EXEC;
        else if (mem_access) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        commit  = mem_ack;
        if (commit) state_next = halt_en ? HALTED : EXEC;
      end
      default: state_next = IDLE;
    endcase
  end

  // Architectural registers: cleared on start, updated only on retire; flags and banks live one instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      im        <= '0;
      dest_bank <= '0;
      src_bank  <= '0;
      flag_lt   <= 1'b0;
      flag_eq   <= 1'b0;
      flag_gt   <= 1'b0;
      done      <= 1'b0;
    end else if (start_go) begin
      pc        <= '0;
      im        <= '0;
      dest_bank <= '0;
      src_bank  <= '0;
      flag_lt   <= 1'b0;
      flag_eq   <= 1'b0;
      flag_gt   <= 1'b0;
      done      <= 1'b0;
    end else if (commit) begin
      pc <= pc_next;
      if (halt_en) begin
        im        <= '0;
        dest_bank <= '0;
        src_bank  <= '0;
        flag_lt   <= 1'b0;
        flag_eq   <= 1'b0;
        flag_gt   <= 1'b0;
        done      <= 1'b1;
      end else begin
        if (load_imm_en) im <= imm_value;
        flag_lt   <= is_cmp && cmp_lt;
        flag_eq   <= is_cmp && cmp_eq;
        flag_gt   <= is_cmp && cmp_gt;
        dest_bank <= set_reg_en ? dest_bank_in : '0;
        src_bank  <= set_reg_en ? src_bank_in  : '0;
      end
    end
  end

`ifdef PERF_COUNTER_EN
  logic [CNT_WIDTH-1:0] count_q;

  // Saturating retire counter, halt included, cleared when a new run starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        count_q <= '0;
    else if (start_go)                 count_q <= '0;
    else if (commit && count_q != '1)  count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign retired_count = count_q;
`else
  assign retired_count = '0;
`endif

endmodule
